// File: rtl/set_time_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : set_time_ctrl
//  Purpose  : Button sequencer for the set_time datapath. Opens the setting
//             window on a mode press, forwards mode/inc strobes (inc with
//             auto-repeat), waits for the datapath ack and then loads the
//             timekeeper, or aborts on inactivity / missing ack.
//  Revision : 1.0 - initial release
// ============================================================================
module set_time_ctrl #(
  parameter int REPEAT_DELAY = 400,
  parameter int REPEAT_RATE  = 100,
  parameter int IDLE_TIMEOUT = 6000,
  parameter int ACK_TIMEOUT  = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic mode_btn,
  input  logic inc_btn,
  input  logic set_ack,
  output logic set_time_en,
  output logic mode_pulse,
  output logic inc_pulse,
  output logic load_time,
  output logic abort_pulse,
  output logic busy
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SET_HR   = 3'd1,
    ST_SET_MIN  = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_LOAD     = 3'd4,
    ST_ABORT    = 3'd5
  } state_t;

  localparam int HOLD_W = $clog2(REPEAT_DELAY + 1);
  localparam int RATE_W = $clog2(REPEAT_RATE + 1);
  localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
  localparam int ACK_W  = $clog2(ACK_TIMEOUT + 1);

  localparam logic [HOLD_W-1:0] C_HOLD_MAX  = HOLD_W'(REPEAT_DELAY);
  localparam logic [RATE_W-1:0] C_RATE_LAST = RATE_W'(REPEAT_RATE - 1);
  localparam logic [IDLE_W-1:0] C_IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);
  localparam logic [ACK_W-1:0]  C_ACK_LAST  = ACK_W'(ACK_TIMEOUT - 1);

  state_t state, next_state;

  logic              r_mode_q, r_inc_q;
  logic [HOLD_W-1:0] r_hold_cnt, w_hold_nxt;
  logic [RATE_W-1:0] r_rate_cnt, w_rate_nxt;
  logic [IDLE_W-1:0] r_idle_cnt, w_idle_nxt;
  logic [ACK_W-1:0]  r_ack_cnt,  w_ack_nxt;
  logic              w_mode_press, w_inc_press, w_in_set, w_repeat;
  logic              w_mode_fire, w_inc_fire;

  // Rising-edge detection of the two button levels
  always_comb begin
    w_mode_press = mode_btn & ~r_mode_q;
    w_inc_press  = inc_btn & ~r_inc_q;
    w_in_set     = (state == ST_SET_HR) || (state == ST_SET_MIN);
  end

  // Auto-repeat: saturating hold counter up to REPEAT_DELAY, then a rate
  // counter that fires every REPEAT_RATE held cycles. A mode press clears both.
  always_comb begin
    w_hold_nxt = '0;
    w_rate_nxt = '0;
    w_repeat   = 1'b0;
    if (w_in_set && inc_btn && !w_mode_press) begin
      if (r_hold_cnt != C_HOLD_MAX) begin
        w_hold_nxt = r_hold_cnt + 1'b1;
        w_repeat   = (w_hold_nxt == C_HOLD_MAX);
      end else begin
        w_hold_nxt = r_hold_cnt;
        if (r_rate_cnt == C_RATE_LAST) begin
          w_repeat = 1'b1;
        end else begin
          w_rate_nxt = r_rate_cnt + 1'b1;
        end
      end
    end
  end

  // Next-state logic plus idle/ack timeout counters and strobe requests
  always_comb begin
    next_state  = state;
    w_idle_nxt  = '0;
    w_ack_nxt   = '0;
    w_mode_fire = 1'b0;
    w_inc_fire  = 1'b0;
    case (state)
      ST_IDLE: begin
        // The entry press opens the window but is not forwarded
        if (w_mode_press) next_state = ST_SET_HR;
      end
      ST_SET_HR, ST_SET_MIN: begin
        if (w_mode_press) begin
          // Mode wins over a simultaneous inc press
          w_mode_fire = 1'b1;
          next_state  = (state == ST_SET_HR) ? ST_SET_MIN : ST_WAIT_ACK;
        end else begin
          w_inc_fire = w_inc_press | w_repeat;
          if (inc_btn) begin
            w_idle_nxt = '0;
          end else if (r_idle_cnt == C_IDLE_LAST) begin
            next_state = ST_ABORT;
          end else begin
            w_idle_nxt = r_idle_cnt + 1'b1;
          end
        end
      end
      ST_WAIT_ACK: begin
        // An ack arriving in the final timeout cycle still loads
        if (set_ack) begin
          next_state = ST_LOAD;
        end else if (r_ack_cnt == C_ACK_LAST) begin
          next_state = ST_ABORT;
        end else begin
          w_ack_nxt = r_ack_cnt + 1'b1;
        end
      end
      ST_LOAD:  next_state = ST_IDLE;
      ST_ABORT: next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Button history, counters and registered outputs derived from next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode_q    <= 1'b0;
      r_inc_q     <= 1'b0;
      r_hold_cnt  <= '0;
      r_rate_cnt  <= '0;
      r_idle_cnt  <= '0;
      r_ack_cnt   <= '0;
      set_time_en <= 1'b0;
      mode_pulse  <= 1'b0;
      inc_pulse   <= 1'b0;
      load_time   <= 1'b0;
      abort_pulse <= 1'b0;
      busy        <= 1'b0;
    end else begin
      r_mode_q    <= mode_btn;
      r_inc_q     <= inc_btn;
      r_hold_cnt  <= w_hold_nxt;
      r_rate_cnt  <= w_rate_nxt;
      r_idle_cnt  <= w_idle_nxt;
      r_ack_cnt   <= w_ack_nxt;
      set_time_en <= (next_state == ST_SET_HR) || (next_state == ST_SET_MIN) ||
                     (next_state == ST_WAIT_ACK);
      mode_pulse  <= w_mode_fire;
      inc_pulse   <= w_inc_fire;
      load_time   <= (next_state == ST_LOAD);
      abort_pulse <= (next_state == ST_ABORT);
      busy        <= (next_state != ST_IDLE);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_set_time_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_set_time_ctrl
//  Purpose  : Self-checking bench for set_time_ctrl (small timing parameters)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_set_time_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mode_btn = 1'b0, inc_btn = 1'b0, set_ack = 1'b0;
  logic set_time_en, mode_pulse, inc_pulse, load_time, abort_pulse, busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  set_time_ctrl #(
    .REPEAT_DELAY (8),
    .REPEAT_RATE  (4),
    .IDLE_TIMEOUT (64),
    .ACK_TIMEOUT  (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mode_btn    (mode_btn),
    .inc_btn     (inc_btn),
    .set_ack     (set_ack),
    .set_time_en (set_time_en),
    .mode_pulse  (mode_pulse),
    .inc_pulse   (inc_pulse),
    .load_time   (load_time),
    .abort_pulse (abort_pulse),
    .busy        (busy)
  );

  // Output vector order: {en, mode_pulse, inc_pulse, load, abort, busy}
  typedef struct {
    logic       m;
    logic       i;
    logic       a;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl[21];

  function automatic logic [5:0] outs();
    return {set_time_en, mode_pulse, inc_pulse, load_time, abort_pulse, busy};
  endfunction

  function automatic vec_t mk(input logic m, input logic i, input logic a, input logic [5:0] e);
    vec_t v;
    v.m = m; v.i = i; v.a = a; v.exp = e;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; mode_btn = 1'b0; inc_btn = 1'b0; set_ack = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic press_mode();
    mode_btn = 1'b1; tick();
    mode_btn = 1'b0; tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses, first_abort, n_abort, n_load;

    // Full session table, including ignored inc/ack while idle
    tbl[0]  = mk(0, 0, 0, 6'b000000);
    tbl[1]  = mk(0, 1, 1, 6'b000000);
    tbl[2]  = mk(0, 0, 0, 6'b000000);
    tbl[3]  = mk(1, 0, 0, 6'b100001);
    tbl[4]  = mk(0, 0, 0, 6'b100001);
    tbl[5]  = mk(0, 1, 0, 6'b101001);
    tbl[6]  = mk(0, 0, 0, 6'b100001);
    tbl[7]  = mk(0, 1, 0, 6'b101001);
    tbl[8]  = mk(0, 0, 0, 6'b100001);
    tbl[9]  = mk(0, 1, 0, 6'b101001);
    tbl[10] = mk(0, 0, 0, 6'b100001);
    tbl[11] = mk(1, 0, 0, 6'b110001);
    tbl[12] = mk(0, 0, 0, 6'b100001);
    tbl[13] = mk(0, 1, 0, 6'b101001);
    tbl[14] = mk(0, 0, 0, 6'b100001);
    tbl[15] = mk(0, 1, 0, 6'b101001);
    tbl[16] = mk(0, 0, 0, 6'b100001);
    tbl[17] = mk(1, 0, 0, 6'b110001);
    tbl[18] = mk(0, 0, 0, 6'b100001);
    tbl[19] = mk(0, 0, 1, 6'b000101);
    tbl[20] = mk(0, 0, 0, 6'b000000);

    do_reset();
    check("reset_outputs", 32'(outs()), 32'h0);

    for (int k = 0; k < 21; k++) begin
      mode_btn = tbl[k].m; inc_btn = tbl[k].i; set_ack = tbl[k].a;
      tick();
      check($sformatf("session_row%0d", k), 32'(outs()), 32'(tbl[k].exp));
    end

    // Held inc: pulses on held cycles 1, 8, 12, 16, 20
    do_reset();
    press_mode();
    inc_btn = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      check($sformatf("repeat_cycle%0d", k), 32'(inc_pulse),
            32'((k == 1) || (k == 8) || (k == 12) || (k == 16) || (k == 20)));
    end
    inc_btn = 1'b0;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (inc_pulse) pulses++;
    end
    check("repeat_stops_after_release", 32'(pulses), 32'd0);
    check("repeat_still_in_session", 32'(set_time_en), 32'd1);

    // Inactivity in SET_MIN: abort exactly 64 cycles after entry press
    do_reset();
    press_mode();
    mode_btn = 1'b1; tick();
    check("enter_set_min_mode_pulse", 32'(mode_pulse), 32'd1);
    mode_btn = 1'b0;
    first_abort = 0; n_abort = 0; n_load = 0;
    for (int k = 1; k <= 80; k++) begin
      tick();
      if (abort_pulse) begin
        n_abort++;
        if (first_abort == 0) begin
          first_abort = k;
          check("idle_abort_en_low", 32'(set_time_en), 32'd0);
        end
      end
      if (load_time) n_load++;
    end
    check("idle_abort_cycle", 32'(first_abort), 32'd64);
    check("idle_abort_count", 32'(n_abort), 32'd1);
    check("idle_no_load", 32'(n_load), 32'd0);
    check("idle_back_to_idle", 32'(busy), 32'd0);

    // Simultaneous mode+inc in SET_HR: mode only, lands in SET_MIN
    do_reset();
    press_mode();
    mode_btn = 1'b1; inc_btn = 1'b1; tick();
    check("simul_press", 32'(outs()), 32'b110001);
    mode_btn = 1'b0; inc_btn = 1'b0; tick();
    check("simul_no_late_inc", 32'(outs()), 32'b100001);
    mode_btn = 1'b1; tick();
    check("simul_next_mode", 32'(outs()), 32'b110001);
    mode_btn = 1'b0;
    // Now in WAIT_ACK (proves the previous state was SET_MIN); no ack -> abort
    inc_btn = 1'b1; tick();
    check("wait_ack_cycle1_inc_ignored", 32'(outs()), 32'b100001);
    inc_btn = 1'b0; tick();
    check("wait_ack_cycle2", 32'(outs()), 32'b100001);
    tick();
    check("wait_ack_cycle3", 32'(outs()), 32'b100001);
    tick();
    check("ack_timeout_abort", 32'(outs()), 32'b000011);
    tick();
    check("ack_timeout_idle", 32'(outs()), 32'b000000);

    // Ack arriving in the final timeout cycle loads
    do_reset();
    press_mode();
    press_mode();
    mode_btn = 1'b1; tick();
    mode_btn = 1'b0;
    tick(); tick(); tick();
    check("late_ack_waiting", 32'(outs()), 32'b100001);
    set_ack = 1'b1; tick();
    check("late_ack_load", 32'(outs()), 32'b000101);
    set_ack = 1'b0; tick();
    check("late_ack_idle", 32'(outs()), 32'b000000);

    // Asynchronous reset mid-session
    do_reset();
    press_mode();
    press_mode();
    check("pre_reset_in_session", 32'(set_time_en), 32'd1);
    #3 rst = 1'b1;
    #1;
    check("async_reset_outputs", 32'(outs()), 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    inc_btn = 1'b1; tick();
    check("post_reset_inc_ignored", 32'(outs()), 32'h0);
    inc_btn = 1'b0; tick();
    check("post_reset_idle", 32'(outs()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
